wb_desc_slave: RTL and testbench

WB_DESC_SLAVE -- requirements
Module: wb_desc_slave

---
 rtl/wb_desc_pkg.sv | 20 ++
 rtl/wb_desc_slave_desc_ram.sv | 34 +++
 rtl/wb_desc_slave.sv | 188 ++++++++++++++++++
 tb/tb_wb_desc_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_desc_pkg.sv
// Shared definitions for the Wishbone descriptor slave: FSM state encoding,
// response codes and the RAM lane width.
package wb_desc_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_BEAT = 3'd2,
        S_GAP  = 3'd3,
        S_RESP = 3'd4
    } state_e;

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_ACK  = 2'd1;
    localparam logic [1:0] RSP_RTY  = 2'd2;
    localparam logic [1:0] RSP_ERR  = 2'd3;

    localparam int LANE_W = 64;

endpackage

// File: rtl/wb_desc_slave_desc_ram.sv
// Synchronous 2^AW x 64 descriptor RAM with one shared read/write port and
// per-byte write enables. Reads are registered; a write cycle returns the
// old contents on rdata_o. Contents are never reset.
module desc_ram
    import wb_desc_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [7:0]        be_i,
    input  logic [LANE_W-1:0] wdata_i,
    output logic [LANE_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] rdata_q;

    // Byte-enabled write and registered read through the single port.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 8; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_desc_slave.sv
// Wishbone classic slave fronting a 64-bit descriptor RAM.
// Optional feature macro: WB_DESC_SLAVE_RTY_EN (hold_i turns into a retry
// response instead of a stall).
//
// Handshake: an access is requested while wbs_cyc_i & wbs_stb_i are high.
// Each beat completes with exactly one registered response (err > rty > ack)
// visible for one cycle. Write data is sampled on the edge that ends the ack
// cycle; read data is valid only while ack is high. Dropping cyc or stb
// cancels the access on the next edge; a write whose ack was already
// presented is still committed on that edge.
module wb_desc_slave
    import wb_desc_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int          AW       = 6,
    parameter int          WAIT     = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cab_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_dat64_i,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] wbs_dat64_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    input  logic        hold_i,
    output logic        busy_o,
    output logic [2:0]  dbg_state_o
);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;     // next beat to issue
    logic [AW-1:0] aptr_q, aptr_d;   // beat currently being acked
    logic          wrap_q, wrap_d;   // pointer ran past the window top
    logic          aerr_q, aerr_d;   // start address outside the window
    logic          we_q, we_d;
    logic          cab_q, cab_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [1:0]    rsp_d;

    logic              req;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [LANE_W-1:0] ram_rdata;
    logic              unused_adr;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign unused_adr = ^wbs_adr_i[2:0];

    // Next-state and response selection for the access FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        aptr_d  = aptr_q;
        wrap_d  = wrap_q;
        aerr_d  = aerr_q;
        we_d    = we_q;
        cab_d   = cab_q;
        rsp_d   = RSP_NONE;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    ptr_d   = wbs_adr_i[AW+2:3];
                    aerr_d  = wbs_adr_i[31:AW+3] != BASE_ADR[31:AW+3];
                    wrap_d  = 1'b0;
                    we_d    = wbs_we_i;
                    cab_d   = wbs_cab_i;
                    cnt_d   = 3'(WAIT);
                    state_d = (WAIT == 0) ? S_BEAT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_BEAT;
                    end
                end
            end
            S_BEAT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (aerr_q || wrap_q) begin
                    rsp_d   = RSP_ERR;
                    state_d = S_RESP;
                end else if (hold_i) begin
`ifdef WB_DESC_SLAVE_RTY_EN
                    rsp_d   = RSP_RTY;
                    state_d = S_RESP;
`else
                    state_d = S_BEAT;
`endif
                end else begin
                    rsp_d  = RSP_ACK;
                    aptr_d = ptr_q;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        wrap_d = 1'b1;
                    end
                    state_d = cab_q ? S_BEAT : S_GAP;
                end
            end
            S_GAP:   state_d = S_IDLE;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ack_d = (rsp_d == RSP_ACK);
    assign err_d = (rsp_d == RSP_ERR);

`ifdef WB_DESC_SLAVE_RTY_EN
    logic rty_q, rty_d;
    assign rty_d     = (rsp_d == RSP_RTY);
    assign wbs_rty_o = rty_q;
`else
    assign wbs_rty_o = 1'b0;
`endif

    // FSM state, beat bookkeeping and registered responses.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            ptr_q   <= '0;
            aptr_q  <= '0;
            wrap_q  <= 1'b0;
            aerr_q  <= 1'b0;
            we_q    <= 1'b0;
            cab_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef WB_DESC_SLAVE_RTY_EN
            rty_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            aptr_q  <= aptr_d;
            wrap_q  <= wrap_d;
            aerr_q  <= aerr_d;
            we_q    <= we_d;
            cab_q   <= cab_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef WB_DESC_SLAVE_RTY_EN
            rty_q   <= rty_d;
`endif
        end
    end

    // A write commits on the edge that closes its ack cycle; otherwise the
    // port reads the next beat so its data lines up with the next ack.
    assign ram_we   = ack_q & we_q;
    assign ram_addr = ram_we ? aptr_q : ptr_q;

    desc_ram #(
        .AW(AW)
    ) u_ram (
        .clk_i  (wb_clk_i),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .be_i   ({wbs_sel_i, wbs_sel_i}),
        .wdata_i({wbs_dat64_i, wbs_dat_i}),
        .rdata_o(ram_rdata)
    );

    assign {wbs_dat64_o, wbs_dat_o} = (ack_q && !we_q) ? ram_rdata : '0;
    assign wbs_ack_o   = ack_q;
    assign wbs_err_o   = err_q;
    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_desc_slave.sv
// Directed bench for wb_desc_slave: one WAIT=0 instance at base 0 and one
// WAIT=3 instance at base 0x1000.
module tb_wb_desc_slave;

  logic        clk;
  logic        rst;
  logic        cyc, stb, cyc_w, stb_w;
  logic        we, cab, hold;
  logic [3:0]  sel;
  logic [31:0] adr, dat_lo, dat_hi;

  logic [31:0] dat_o, dat64_o, dat_o_w, dat64_o_w;
  logic        ack, err, rty, busy, ack_w, err_w, rty_w, busy_w;
  logic [2:0]  dbg, dbg_w;

  int checks;
  int errors;

  wb_desc_slave #(.BASE_ADR(32'h0000_0000), .AW(6), .WAIT(0)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_cab_i(cab),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_lo), .wbs_dat64_i(dat_hi),
    .wbs_dat_o(dat_o), .wbs_dat64_o(dat64_o),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty),
    .hold_i(hold), .busy_o(busy), .dbg_state_o(dbg)
  );

  wb_desc_slave #(.BASE_ADR(32'h0000_1000), .AW(6), .WAIT(3)) dut_w (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc_w), .wbs_stb_i(stb_w), .wbs_we_i(we), .wbs_cab_i(cab),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_lo), .wbs_dat64_i(dat_hi),
    .wbs_dat_o(dat_o_w), .wbs_dat64_o(dat64_o_w),
    .wbs_ack_o(ack_w), .wbs_err_o(err_w), .wbs_rty_o(rty_w),
    .hold_i(hold), .busy_o(busy_w), .dbg_state_o(dbg_w)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one single (cab=0) access on dut with WAIT=0; stb is held
  // through the gap cycle so a missing gap would show as a second response
  task automatic do_single(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] lo, input logic [31:0] hi,
                           output logic ack1, output logic err1, output logic rsp2,
                           output logic [31:0] rlo, output logic [31:0] rhi);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; cab = 1'b0; adr = a; sel = s;
    dat_lo = lo; dat_hi = hi;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ack1 = ack; err1 = err; rlo = dat_o; rhi = dat64_o;
    @(posedge clk);
    @(negedge clk);
    rsp2 = ack | err | rty;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc = 0; stb = 0; cyc_w = 0; stb_w = 0; we = 0; cab = 0; hold = 0;
    sel = 4'h0; adr = 32'h0; dat_lo = 32'h0; dat_hi = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, err, rty, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_resp got %b exp 0000", {ack, err, rty, busy});
    end
    checks++;
    if ({dat64_o, dat_o} !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {dat64_o, dat_o});
    end
    checks++;
    if ({ack_w, err_w, rty_w, busy_w} !== 4'b0000) begin
      errors++; $display("FAIL reset_resp_w got %b exp 0000", {ack_w, err_w, rty_w, busy_w});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_burst_write_read();
    logic [31:0] v;
    // 4-beat write burst at word 0
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; cab = 1; adr = 32'h0; sel = 4'hF;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      v = 32'h1111_1111 * k;
      dat_lo = v; dat_hi = v;
      if (k == 3) begin cyc = 0; stb = 0; end
      @(negedge clk);
      checks++;
      if (ack !== 1'b1) begin
        errors++; $display("FAIL bw_ack beat %0d got %b exp 1", k, ack);
      end
    end
    @(posedge clk); #1;
    we = 0;
    @(negedge clk);
    checks++;
    if ({ack, busy} !== 2'b00) begin
      errors++; $display("FAIL bw_end got ack,busy=%b exp 00", {ack, busy});
    end
    // 4-beat read burst of the same words
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; cab = 1; adr = 32'h0;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin cyc = 0; stb = 0; end
      @(negedge clk);
      v = 32'h1111_1111 * k;
      checks++;
      if (ack !== 1'b1 || dat_o !== v || dat64_o !== v) begin
        errors++; $display("FAIL br_beat %0d got ack=%b %h_%h exp 1 %h_%h", k, ack, dat64_o, dat_o, v, v);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, busy, dat_o} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL br_end got ack=%b busy=%b lo=%h exp 0 0 0", ack, busy, dat_o);
    end
  endtask

  task automatic test_wait_read();
    logic exp_ack;
    logic exp_busy;
    @(posedge clk); #1;
    cyc_w = 1; stb_w = 1; we = 0; cab = 0; adr = 32'h0000_1008;
    // stb first sampled at edge 1; ack due 4 edges later (edge 5), gap after
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_ack  = (c == 5);
      exp_busy = (c <= 5);
      checks++;
      if (ack_w !== exp_ack || err_w !== 1'b0 || busy_w !== exp_busy) begin
        errors++; $display("FAIL wait_cycle %0d got ack=%b err=%b busy=%b exp %b 0 %b", c, ack_w, err_w, busy_w, exp_ack, exp_busy);
      end
      if (c == 5) begin cyc_w = 0; stb_w = 0; end
    end
  endtask

  task automatic test_sel_write();
    logic a1, e1, r2;
    logic [31:0] lo, hi;
    do_single(1'b1, 32'h20, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if ({a1, e1, r2} !== 3'b100) begin
      errors++; $display("FAIL single_wr_resp got ack,err,gap=%b exp 100", {a1, e1, r2});
    end
    do_single(1'b1, 32'h20, 4'b0011, 32'hAAAA_BBBB, 32'h0, a1, e1, r2, lo, hi);
    do_single(1'b0, 32'h20, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if ({a1, e1, r2} !== 3'b100 || lo !== 32'h0000_BBBB || hi !== 32'h0) begin
      errors++; $display("FAIL sel_0011 got %b %h_%h exp 100 00000000_0000bbbb", {a1, e1, r2}, hi, lo);
    end
    do_single(1'b1, 32'h28, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    do_single(1'b1, 32'h28, 4'b1100, 32'h1234_5678, 32'hCAFE_F00D, a1, e1, r2, lo, hi);
    do_single(1'b0, 32'h28, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if (lo !== 32'h1234_0000 || hi !== 32'hCAFE_0000) begin
      errors++; $display("FAIL sel_1100 got %h_%h exp cafe0000_12340000", hi, lo);
    end
  endtask

  task automatic test_err();
    logic a1, e1, r2;
    logic [31:0] lo, hi;
    // one word past the window top
    do_single(1'b0, 32'h200, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if ({a1, e1, r2} !== 3'b010) begin
      errors++; $display("FAIL err_outside got ack,err,next=%b exp 010", {a1, e1, r2});
    end
    // burst from the last word: ack then err on beat 2
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; cab = 1; adr = 32'h1F8;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, err} !== 2'b10) begin
      errors++; $display("FAIL wrap_beat1 got ack,err=%b exp 10", {ack, err});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, err} !== 2'b01) begin
      errors++; $display("FAIL wrap_beat2 got ack,err=%b exp 01", {ack, err});
    end
    cyc = 0; stb = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, err, busy} !== 3'b000) begin
      errors++; $display("FAIL wrap_end got ack,err,busy=%b exp 000", {ack, err, busy});
    end
  endtask

  task automatic test_hold();
    logic a1, e1, r2;
    logic [31:0] lo, hi;
    do_single(1'b1, 32'h30, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    @(posedge clk); #1;
    hold = 1;
    cyc = 1; stb = 1; we = 1; cab = 0; adr = 32'h30; sel = 4'hF;
    dat_lo = 32'h5555_5555; dat_hi = 32'h6666_6666;
    @(posedge clk);
`ifdef WB_DESC_SLAVE_RTY_EN
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, err, rty} !== 3'b001) begin
      errors++; $display("FAIL hold_rty got ack,err,rty=%b exp 001", {ack, err, rty});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, rty} !== 2'b00) begin
      errors++; $display("FAIL hold_rty_end got ack,rty=%b exp 00", {ack, rty});
    end
    cyc = 0; stb = 0; we = 0; hold = 0;
    do_single(1'b0, 32'h30, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if (lo !== 32'h0 || hi !== 32'h0) begin
      errors++; $display("FAIL rty_dropped got %h_%h exp 0_0", hi, lo);
    end
`else
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ack, err, rty, busy} !== 4'b0001) begin
        errors++; $display("FAIL hold_stall %0d got ack,err,rty,busy=%b exp 0001", c, {ack, err, rty, busy});
      end
    end
    hold = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("FAIL hold_release got ack=%b exp 1", ack);
    end
    @(posedge clk);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    do_single(1'b0, 32'h30, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if (lo !== 32'h5555_5555 || hi !== 32'h6666_6666) begin
      errors++; $display("FAIL hold_data got %h_%h exp 66666666_55555555", hi, lo);
    end
`endif
  endtask

  task automatic test_abort();
    logic a1, e1, r2;
    logic [31:0] lo, hi;
    do_single(1'b1, 32'h50, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; cab = 1; adr = 32'h40; sel = 4'hF;
    @(posedge clk);
    @(posedge clk); #1;
    dat_lo = 32'h8080_8080; dat_hi = 32'h0808_0808;
    @(posedge clk); #1;
    dat_lo = 32'h9090_9090; dat_hi = 32'h0909_0909;
    cyc = 0; stb = 0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("FAIL abort_beat2 got ack=%b exp 1", ack);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, busy} !== 2'b00) begin
      errors++; $display("FAIL abort_next got ack,busy=%b exp 00", {ack, busy});
    end
    we = 0;
    do_single(1'b0, 32'h48, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if (lo !== 32'h9090_9090 || hi !== 32'h0909_0909) begin
      errors++; $display("FAIL abort_committed got %h_%h exp 09090909_90909090", hi, lo);
    end
    do_single(1'b0, 32'h50, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if (lo !== 32'h0 || hi !== 32'h0) begin
      errors++; $display("FAIL abort_beat3_absent got %h_%h exp 0_0", hi, lo);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic a1, e1, r2;
    logic [31:0] lo, hi;
    do_single(1'b1, 32'h60, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; cab = 1; adr = 32'h60; sel = 4'hF;
    @(posedge clk);
    @(posedge clk); #1;
    dat_lo = 32'hDEAD_BEEF; dat_hi = 32'hFEED_FACE;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got ack=%b exp 1", ack);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ack, busy} !== 2'b00) begin
      errors++; $display("FAIL rstmid_async got ack,busy=%b exp 00", {ack, busy});
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    rst = 1'b0;
    do_single(1'b0, 32'h60, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if (lo !== 32'h0 || hi !== 32'h0) begin
      errors++; $display("FAIL rstmid_no_commit got %h_%h exp 0_0", hi, lo);
    end
    do_single(1'b0, 32'h08, 4'hF, 32'h0, 32'h0, a1, e1, r2, lo, hi);
    checks++;
    if (lo !== 32'h1111_1111 || hi !== 32'h1111_1111) begin
      errors++; $display("FAIL rstmid_ram_kept got %h_%h exp 11111111_11111111", hi, lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_burst_write_read();
    test_wait_read();
    test_sel_write();
    test_err();
    test_hold();
    test_abort();
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
